clk_div_gen: RTL and testbench

Programmable clock-divider stage that drives `custom_clk` for the LED cycle and other slow-rate display logic on the DE1-SoC. It divides the 50 MHz board clock by an even, run-time-loadable ratio and produces a 50 % duty square wave plus a one-cycle `tick` strobe on each rising edge. A new divisor can be loaded at any time. It takes effect only at a full-period boundary, so downstream logic never sees a runt pulse.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_gen.sv | 153 +++++++++++++++
 tb/tb_clk_div_gen.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg
// Shared types and constants for the programmable clock divider.
//   phase_t       : which half of the output period is in progress
//   DIV_W_DEFAULT : default width of the divisor / half-period counter
//   MIN_DIV       : smallest usable half-period (a captured 0 maps to this)
package clk_div_pkg;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    localparam int unsigned DIV_W_DEFAULT = 32;
    localparam int unsigned MIN_DIV       = 1;

endpackage

// File: rtl/clk_div_gen.sv
// clk_div_gen
// Divides clk by an even, run-time-loadable ratio 2N and produces a 50 % duty
// square wave (custom_clk) plus a one-cycle tick on every rising edge.
// A newly loaded N only takes effect at the end of a full period (falling edge
// of custom_clk), so downstream logic never sees a runt pulse.
//
// Optional feature macro: CLK_DIV_PAUSE_EN adds the 'pause' input, which
// freezes the divider while still capturing loads.
//
// Ports:
//   clk        in   system clock (50 MHz on the board)
//   reset      in   asynchronous, active-high reset
//   div_value  in   [DIV_W] requested half-period N in clk cycles
//   div_load   in   single-cycle strobe capturing div_value
//   custom_clk out  divided clock, registered, period 2N
//   tick       out  one-clk pulse coincident with each custom_clk rise
//   load_ack   out  one-clk pulse when a new divisor becomes active
//   pause      in   hold everything (only with CLK_DIV_PAUSE_EN)
//   phase_dbg  out  current phase FSM state (0 = PH_LOW, 1 = PH_HIGH)
//
// Handshake: div_load is a fire-and-forget strobe (no ready); the last load
// before a period boundary wins and produces exactly one load_ack.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div_value,
    input  logic             div_load,
    output logic             custom_clk,
    output logic             tick,
    output logic             load_ack,
`ifdef CLK_DIV_PAUSE_EN
    input  logic             pause,
`endif
    output logic             phase_dbg
);

    localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);
    localparam logic [DIV_W-1:0] DEFAULT_EFF =
        (DEFAULT_DIV < MIN_DIV) ? DIV_W'(MIN_DIV) : DIV_W'(DEFAULT_DIV);

    // A requested half-period of 0 would never terminate; clamp it.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] v);
        return (v == '0) ? DIV_W'(MIN_DIV) : v;
    endfunction

    phase_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             run;
    logic             at_end;

`ifdef CLK_DIV_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    // cnt never exceeds div_act-1, so equality is the only terminal test.
    assign at_end = (cnt_q == div_act_q - ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PH_LOW;
            cnt_q      <= '0;
            div_act_q  <= DEFAULT_EFF;
            div_pend_q <= '0;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_vld_d = pend_vld_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        ack_d      = 1'b0;

        // Loads are always captured, even while paused.
        if (div_load) begin
            div_pend_d = eff_div(div_value);
            pend_vld_d = 1'b1;
        end

        if (run) begin
            unique case (state_q)
                PH_LOW: begin
                    if (at_end) begin
                        state_d   = PH_HIGH;
                        cnt_d     = '0;
                        clk_out_d = 1'b1;
                        tick_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                PH_HIGH: begin
                    if (at_end) begin
                        // Period boundary: the only place div_act may change.
                        state_d   = PH_LOW;
                        cnt_d     = '0;
                        clk_out_d = 1'b0;
                        if (div_load) begin
                            // Same-cycle load bypasses the pending slot.
                            div_act_d  = eff_div(div_value);
                            pend_vld_d = 1'b0;
                            ack_d      = 1'b1;
                        end else if (pend_vld_q) begin
                            div_act_d  = div_pend_q;
                            pend_vld_d = 1'b0;
                            ack_d      = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = PH_LOW;
                end
            endcase
        end
    end

    assign custom_clk = clk_out_q;
    assign tick       = tick_q;
    assign load_ack   = ack_q;
    assign phase_dbg  = state_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen
// Directed bench for clk_div_gen with DEFAULT_DIV = 4. A period-position model
// (edges elapsed since the start of the current period) predicts every output
// each cycle; directed scenarios add literal checks at hand-computed edges.
module tb_clk_div_gen;

    localparam int DIV_W = 16;
    localparam int DEF_N = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [DIV_W-1:0] div_value = '0;
    logic             div_load = 1'b0;
    logic             pause = 1'b0;
    logic             custom_clk;
    logic             tick;
    logic             load_ack;
    logic             phase_dbg;

    int vectors = 0;
    int miscompares = 0;
    int e = 0;
    int acks = 0;

    always #5 clk = ~clk;

    clk_div_gen #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(DEF_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .div_value (div_value),
        .div_load  (div_load),
        .custom_clk(custom_clk),
        .tick      (tick),
        .load_ack  (load_ack),
`ifdef CLK_DIV_PAUSE_EN
        .pause     (pause),
`endif
        .phase_dbg (phase_dbg)
    );

    // ---------------- model ----------------
    int m_n, m_pos, m_pend;
    bit m_pvld, m_clk, m_tick, m_ack, m_bound, m_paused;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n = DEF_N; m_pos = 0; m_pend = 0; m_pvld = 0;
            m_clk = 0; m_tick = 0; m_ack = 0;
        end else begin
            m_tick = 0; m_ack = 0; m_bound = 0;
`ifdef CLK_DIV_PAUSE_EN
            m_paused = pause;
`else
            m_paused = 0;
`endif
            if (!m_paused) begin
                m_pos++;
                if (m_pos == m_n) m_tick = 1;
                if (m_pos == 2 * m_n) begin m_bound = 1; m_pos = 0; end
            end
            if (m_bound && div_load) begin
                m_n = eff(int'(div_value)); m_ack = 1; m_pvld = 0;
            end else if (m_bound && m_pvld) begin
                m_n = m_pend; m_ack = 1; m_pvld = 0;
            end else if (div_load) begin
                m_pend = eff(int'(div_value)); m_pvld = 1;
            end
            m_clk = (m_pos >= m_n);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b (edge %0d, t=%0t)", name, act, exp, e, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_custom_clk", custom_clk, m_clk);
        chk("model_tick", tick, m_tick);
        chk("model_load_ack", load_ack, m_ack);
        chk("model_phase", phase_dbg, m_clk);
        if (load_ack === 1'b1) acks++;
    end

    // ---------------- driver tasks ----------------
    task automatic start();
        #1 reset = 1'b1;
        div_load = 1'b0; div_value = '0; pause = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        e = 0; acks = 0;
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        @(negedge clk);
    endtask

    task automatic run_to(input int k);
        while (e < k) step();
    endtask

    // load sampled on edge k
    task automatic load_at(input int k, input int v);
        run_to(k - 1);
        div_value = DIV_W'(v);
        div_load  = 1'b1;
        step();
        div_load  = 1'b0;
    endtask

    // Default N=4 wave from reset release, checked against hand rules.
    task automatic check_default_wave(input string tag);
        for (int k = 1; k <= 24; k++) begin
            step();
            chk({tag, "_clk"}, custom_clk, ((k % 8) >= 4));
            chk({tag, "_tick"}, tick, ((k % 8) == 4));
        end
    endtask

    initial begin
        // 1: reset state and default wave
        @(negedge clk);
        chk("reset_clk", custom_clk, 1'b0);
        chk("reset_tick", tick, 1'b0);
        chk("reset_ack", load_ack, 1'b0);
        start();
        check_default_wave("s1");
        chk("s1_no_ack", (acks == 0), 1'b1);

        // 2: load 2 at edge 5
        start();
        load_at(5, 2);
        run_to(7);  chk("s2_clk_e7", custom_clk, 1'b1);
        run_to(8);  chk("s2_clk_e8", custom_clk, 1'b0); chk("s2_ack_e8", load_ack, 1'b1);
        run_to(9);  chk("s2_ack_e9", load_ack, 1'b0);  chk("s2_clk_e9", custom_clk, 1'b0);
        run_to(10); chk("s2_clk_e10", custom_clk, 1'b1); chk("s2_tick_e10", tick, 1'b1);
        run_to(11); chk("s2_clk_e11", custom_clk, 1'b1);
        run_to(12); chk("s2_clk_e12", custom_clk, 1'b0);
        run_to(14); chk("s2_tick_e14", tick, 1'b1);
        run_to(20); chk("s2_one_ack", (acks == 1), 1'b1);

        // 3: load 0 -> half-period 1
        start();
        load_at(5, 0);
        run_to(8); chk("s3_ack_e8", load_ack, 1'b1);
        for (int k = 9; k <= 14; k++) begin
            step();
            chk("s3_toggle", custom_clk, (k % 2 == 1));
            chk("s3_tick", tick, (k % 2 == 1));
        end

        // 4: loads 6 then 3 in one period -> one ack, N=3
        start();
        load_at(5, 6);
        load_at(6, 3);
        run_to(8);  chk("s4_ack_e8", load_ack, 1'b1);
        run_to(10); chk("s4_clk_e10", custom_clk, 1'b0);
        run_to(11); chk("s4_clk_e11", custom_clk, 1'b1);
        run_to(13); chk("s4_clk_e13", custom_clk, 1'b1);
        run_to(14); chk("s4_clk_e14", custom_clk, 1'b0);
        run_to(24); chk("s4_one_ack", (acks == 1), 1'b1);

        // 5: load coincident with the boundary edge 8
        start();
        load_at(8, 2);
        chk("s5_ack_e8", load_ack, 1'b1);
        run_to(10); chk("s5_clk_e10", custom_clk, 1'b1);
        run_to(12); chk("s5_clk_e12", custom_clk, 1'b0);
        run_to(24); chk("s5_one_ack", (acks == 1), 1'b1);

        // 6: async reset while high with a load pending
        start();
        load_at(5, 2);
        run_to(6);
        chk("s6_high_before", custom_clk, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("s6_async_clk", custom_clk, 1'b0);
        chk("s6_async_tick", tick, 1'b0);
        chk("s6_async_ack", load_ack, 1'b0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        e = 0; acks = 0;
        check_default_wave("s6");
        chk("s6_no_ack", (acks == 0), 1'b1);

`ifdef CLK_DIV_PAUSE_EN
        // 7: pause sampled on edges 6..15 during the high phase
        start();
        run_to(5);
        pause = 1'b1;
        for (int k = 6; k <= 15; k++) begin
            step();
            chk("s7_hold_clk", custom_clk, 1'b1);
            chk("s7_no_tick", tick, 1'b0);
        end
        pause = 1'b0;
        run_to(17); chk("s7_clk_e17", custom_clk, 1'b1);
        run_to(18); chk("s7_fall_e18", custom_clk, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
